alarm_bank: RTL and testbench
=============================

Name: alarm_bank

Overview:
Parametrised successor to the single-alarm block. Holds NUM_ALARMS independent alarm channels, each with its own enable, time and state machine. Adds snooze, dismiss, an auto-off ring timeout and a validated configuration handshake. Sits beside the seconds counter, consuming its timestamp and a one-cycle tick, and drives the output/formatting block.

Parameters:
NUM_ALARMS, 4, number of alarm channels (1..16)
COUNTER_MAX, 86399, last valid timestamp; the counter wraps to 0 after it
COUNTER_W, 17, timestamp width; must satisfy 2**COUNTER_W > COUNTER_MAX
SNOOZE_SECS, 540, snooze length in ticks (1..COUNTER_MAX)
RING_TIMEOUT, 3600, ticks spent RINGING before auto-off (>=1)

Ports:
clock  in  1  single system clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
tick  in  1  one-cycle pulse; counter_state has just advanced
counter_state  in  COUNTER_W  current timestamp (0..COUNTER_MAX)
set_flag  in  1  time is being set; suppresses all matches
cfg_valid  in  1  configuration request
cfg_ready  out  1  block can accept a configuration request
cfg_index  in  4  channel to configure
cfg_enable  in  1  1 = arm the channel at cfg_time; 0 = disable it
cfg_time  in  COUNTER_W  alarm timestamp
cfg_error  out  1  one-cycle pulse when a request is rejected
snooze  in  1  pulse; applies to every RINGING channel
dismiss  in  1  pulse; applies to every RINGING or SNOOZED channel
ringing  out  NUM_ALARMS  per-channel ringing flags
alarm_state  out  1  OR of ringing
active_index  out  4  lowest ringing channel index; 0 when none

Behaviour:
- Reset, whether at start-up or mid-operation, overrides everything. After reset: all channels DISABLED, stored times 0, ringing=0, alarm_state=0, active_index=0, cfg_error=0, cfg_ready=0. cfg_ready goes to 1 on the first cycle after reset deasserts and then stays 1.
- Handshake: a request is accepted when cfg_valid && cfg_ready. The new state is visible on the next clock edge (1-cycle latency). Holding cfg_valid high rewrites the channel every cycle.
- Rejection: a request with cfg_index >= NUM_ALARMS, or with cfg_enable=1 and cfg_time > COUNTER_MAX, is dropped. cfg_error pulses 1 the following cycle and no state changes. A disable request ignores cfg_time.
- Per-channel states are DISABLED, ARMED, RINGING and SNOOZED.
  - Accepted write, enable=0: any state -> DISABLED.
  - Accepted write, enable=1: any state -> ARMED with the new time. This clears ringing and any pending snooze.
  - ARMED -> RINGING when tick && !set_flag && counter_state == stored time. The ring counter is cleared to 0.
  - RINGING -> ARMED on dismiss. The time is kept, so the alarm re-fires on the next day.
  - RINGING -> SNOOZED on snooze. snooze_target = (counter_state + SNOOZE_SECS), minus (COUNTER_MAX+1) if the sum exceeds COUNTER_MAX. Compute this in COUNTER_W+1 bits.
  - RINGING: the ring counter increments on each tick. When it reaches RING_TIMEOUT, the channel returns to ARMED (auto-off).
  - SNOOZED -> RINGING when tick && !set_flag && counter_state == snooze_target. The ring counter is cleared.
  - SNOOZED -> ARMED on dismiss.
- Priority within one channel, highest first: reset, accepted write to this channel, dismiss, snooze, timeout, match. Channels are evaluated independently in the same cycle.
- If snooze and a match arrive in the same cycle, a RINGING channel snoozes while an ARMED channel still starts ringing.
- Matches suppressed by set_flag are lost; they are not deferred.
- ringing[i] = 1 in the RINGING state. All outputs are registered and reflect the state after the edge.
- The ring counter width is $clog2(RING_TIMEOUT+1).

Decomposition:
- Shared package clock_pkg: COUNTER_MAX, COUNTER_W, a counter typedef, the channel-state enum, and the wrap-add function for snooze_target.
- One sub-module, alarm_channel: the per-channel FSM, stored time, snooze target and ring counter. alarm_bank instantiates it NUM_ALARMS times with a generate loop and performs request decode, validation, the OR reduction and the priority encoding for active_index.

Test Plan:
- Reset, then arm channel 2 at 100; drive tick with counter_state 99 then 100 -> ringing=4'b0100, alarm_state=1, active_index=2 one cycle after the tick at 100.
- Channel 0 ringing at 86000; pulse snooze -> SNOOZED, ringing[0]=0; tick at 140 (wrapped target) -> ringing[0]=1 again; pulse dismiss -> ARMED, ringing=0.
- Rejection: cfg_index=5 with NUM_ALARMS=4 -> cfg_error=1 for one cycle, no state change; cfg_time=86400 with enable=1 -> cfg_error=1; an in-range request -> cfg_error=0.
- Simultaneous events: channel 1 ringing and channel 3 armed at 500; snooze pulse together with the tick at 500 -> ringing=4'b1000, active_index=3.
- Timeout and set_flag: RING_TIMEOUT=3, channel 0 ringing; 3 ticks -> ringing[0]=0, state ARMED. Tick at the armed time with set_flag=1 -> no ring.
- Reset mid-operation: two channels ringing, assert reset for one cycle -> all outputs 0, cfg_ready=0 during reset and 1 on the cycle after deassertion; a subsequent tick at the old time -> no ring.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared timekeeping types for the alarm bank.
// Channel state encoding and the wrapping snooze adder.
package clock_pkg;

  localparam int COUNTER_MAX = 86399;
  localparam int COUNTER_W   = 17;

  typedef logic [COUNTER_W-1:0] counter_t;

  typedef enum logic [1:0] {
    CH_DISABLED,
    CH_ARMED,
    CH_RINGING,
    CH_SNOOZED
  } chan_state_e;

  // a + b modulo (max + 1); operands are below max + 1
  function automatic int unsigned wrap_add(
    input int unsigned a,
    input int unsigned b,
    input int unsigned max
  );
    int unsigned sum;
    sum = a + b;
    if (sum > max) sum = sum - (max + 1);
    return sum;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: state machine, stored time,
// snooze target and ring-duration counter.
module alarm_channel #(
  parameter int CNT_W   = 17,
  parameter int CNT_MAX = 86399,
  parameter int SNOOZE  = 540,
  parameter int TIMEOUT = 3600
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] counter_state_i,
  input  logic             set_flag_i,
  input  logic             wr_i,
  input  logic             arm_i,
  input  logic [CNT_W-1:0] wr_time_i,
  input  logic             snooze_i,
  input  logic             dismiss_i,
  output logic             ring_o,
  output logic             ring_next_o
);
  import clock_pkg::*;

  localparam int RW = $clog2(TIMEOUT + 1);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] time_q, time_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic             hit_time, hit_tgt;

  assign hit_time = tick_i && !set_flag_i
                 && counter_state_i == time_q;
  assign hit_tgt  = tick_i && !set_flag_i
                 && counter_state_i == tgt_q;

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    tgt_d   = tgt_q;
    rcnt_d  = rcnt_q;
    if (wr_i) begin
      if (arm_i) begin
        state_d = CH_ARMED;
        time_d  = wr_time_i;
        rcnt_d  = '0;
      end else begin
        state_d = CH_DISABLED;
      end
    end else begin
      unique case (state_q)
        CH_ARMED: begin
          if (hit_time) begin
            state_d = CH_RINGING;
            rcnt_d  = '0;
          end
        end
        CH_RINGING: begin
          if (dismiss_i) begin
            state_d = CH_ARMED;
          end else if (snooze_i) begin
            state_d = CH_SNOOZED;
            tgt_d   = CNT_W'(wrap_add(
              32'(counter_state_i), SNOOZE, CNT_MAX));
          end else if (tick_i) begin
            // auto-off once this tick completes the timeout
            if (rcnt_q == RW'(TIMEOUT - 1))
              state_d = CH_ARMED;
            rcnt_d = rcnt_q + RW'(1);
          end
        end
        CH_SNOOZED: begin
          if (dismiss_i) begin
            state_d = CH_ARMED;
          end else if (hit_tgt) begin
            state_d = CH_RINGING;
            rcnt_d  = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CH_DISABLED;
      time_q  <= '0;
      tgt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      tgt_q   <= tgt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign ring_o      = state_q == CH_RINGING;
  assign ring_next_o = state_d == CH_RINGING;

endmodule

// File: rtl/alarm_bank.sv
// Bank of independent alarm channels with a validated
// configuration port, snooze/dismiss and ring summary.
module alarm_bank #(
  parameter int NUM_ALARMS   = 4,
  parameter int COUNTER_MAX  = clock_pkg::COUNTER_MAX,
  parameter int COUNTER_W    = clock_pkg::COUNTER_W,
  parameter int SNOOZE_SECS  = 540,
  parameter int RING_TIMEOUT = 3600
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [COUNTER_W-1:0]  counter_state,
  input  logic                  set_flag,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_index,
  input  logic                  cfg_enable,
  input  logic [COUNTER_W-1:0]  cfg_time,
  output logic                  cfg_error,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  alarm_state,
  output logic [3:0]            active_index
);

  logic                  ready_q, err_q, alarm_q;
  logic [3:0]            act_q, act_d;
  logic [NUM_ALARMS-1:0] ring, ring_nx, wr;
  logic                  req, bad;

  assign req = cfg_valid && ready_q;
  // a disable request is valid for any cfg_time
  assign bad = 32'(cfg_index) >= NUM_ALARMS
            || (cfg_enable && 32'(cfg_time) > COUNTER_MAX);

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    assign wr[i] = req && !bad && cfg_index == 4'(i);

    alarm_channel #(
      .CNT_W   (COUNTER_W),
      .CNT_MAX (COUNTER_MAX),
      .SNOOZE  (SNOOZE_SECS),
      .TIMEOUT (RING_TIMEOUT)
    ) u_ch (
      .clock           (clock),
      .reset           (reset),
      .tick_i          (tick),
      .counter_state_i (counter_state),
      .set_flag_i      (set_flag),
      .wr_i            (wr[i]),
      .arm_i           (cfg_enable),
      .wr_time_i       (cfg_time),
      .snooze_i        (snooze),
      .dismiss_i       (dismiss),
      .ring_o          (ring[i]),
      .ring_next_o     (ring_nx[i])
    );
  end

  always_comb begin
    act_d = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--)
      if (ring_nx[i]) act_d = 4'(i);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      alarm_q <= 1'b0;
      act_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      err_q   <= req && bad;
      alarm_q <= |ring_nx;
      act_q   <= act_d;
    end
  end

  assign cfg_ready    = ready_q;
  assign cfg_error    = err_q;
  assign ringing      = ring;
  assign alarm_state  = alarm_q;
  assign active_index = act_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed vector table plus randomized traffic checked
// against a rule-level model of the alarm bank.
module tb_alarm_bank;

  localparam int NA   = 4;
  localparam int CMAX = 86399;
  localparam int SN   = 540;
  localparam int RT   = 3;

  localparam int S_OFF  = 0;
  localparam int S_ARM  = 1;
  localparam int S_RING = 2;
  localparam int S_SNZ  = 3;

  logic        clock = 0;
  logic        reset = 1;
  logic        tick = 0;
  logic [16:0] counter_state = 0;
  logic        set_flag = 0;
  logic        cfg_valid = 0;
  logic        cfg_ready;
  logic [3:0]  cfg_index = 0;
  logic        cfg_enable = 0;
  logic [16:0] cfg_time = 0;
  logic        cfg_error;
  logic        snooze = 0;
  logic        dismiss = 0;
  logic [3:0]  ringing;
  logic        alarm_state;
  logic [3:0]  active_index;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alarm_bank #(
    .NUM_ALARMS   (NA),
    .COUNTER_MAX  (CMAX),
    .COUNTER_W    (17),
    .SNOOZE_SECS  (SN),
    .RING_TIMEOUT (RT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .tick          (tick),
    .counter_state (counter_state),
    .set_flag      (set_flag),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_index     (cfg_index),
    .cfg_enable    (cfg_enable),
    .cfg_time      (cfg_time),
    .cfg_error     (cfg_error),
    .snooze        (snooze),
    .dismiss       (dismiss),
    .ringing       (ringing),
    .alarm_state   (alarm_state),
    .active_index  (active_index)
  );

  // reference model: per-channel mode, time, target, ticks left
  int m_st[NA];
  int m_time[NA];
  int m_tgt[NA];
  int m_left[NA];
  bit m_rdy = 0;
  bit m_err = 0;

  task automatic model_step();
    bit acc, bad, hit;
    int cs;
    cs = int'(counter_state);
    if (reset) begin
      for (int c = 0; c < NA; c++) begin
        m_st[c] = S_OFF;
        m_time[c] = 0;
      end
      m_rdy = 0;
      m_err = 0;
      return;
    end
    acc = cfg_valid && m_rdy;
    bad = int'(cfg_index) >= NA
       || (cfg_enable && int'(cfg_time) > CMAX);
    m_err = acc && bad;
    for (int c = 0; c < NA; c++) begin
      if (acc && !bad && int'(cfg_index) == c) begin
        if (cfg_enable) begin
          m_st[c] = S_ARM;
          m_time[c] = int'(cfg_time);
        end else begin
          m_st[c] = S_OFF;
        end
      end else if (m_st[c] == S_ARM) begin
        hit = tick && !set_flag && cs == m_time[c];
        if (hit) begin
          m_st[c] = S_RING;
          m_left[c] = RT;
        end
      end else if (m_st[c] == S_RING) begin
        if (dismiss) m_st[c] = S_ARM;
        else if (snooze) begin
          m_st[c] = S_SNZ;
          m_tgt[c] = (cs + SN) % (CMAX + 1);
        end else if (tick) begin
          m_left[c]--;
          if (m_left[c] == 0) m_st[c] = S_ARM;
        end
      end else if (m_st[c] == S_SNZ) begin
        hit = tick && !set_flag && cs == m_tgt[c];
        if (dismiss) m_st[c] = S_ARM;
        else if (hit) begin
          m_st[c] = S_RING;
          m_left[c] = RT;
        end
      end
    end
    m_rdy = 1;
  endtask

  function automatic logic [3:0] m_ring();
    logic [3:0] r;
    r = '0;
    for (int c = 0; c < NA; c++)
      r[c] = m_st[c] == S_RING;
    return r;
  endfunction

  function automatic logic [3:0] m_act();
    for (int c = 0; c < NA; c++)
      if (m_st[c] == S_RING) return 4'(c);
    return 4'd0;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h",
               nm, $time, a, e);
    end
  endtask

  task automatic chk_model();
    chk("m_ring", 32'(ringing), 32'(m_ring()));
    chk("m_alarm", 32'(alarm_state), 32'(|m_ring()));
    chk("m_act", 32'(active_index), 32'(m_act()));
    chk("m_ready", 32'(cfg_ready), 32'(m_rdy));
    chk("m_err", 32'(cfg_error), 32'(m_err));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    #1;
  endtask

  typedef struct {
    bit r, tk;
    int cs;
    bit sf, v;
    int ix;
    bit en;
    int tm;
    bit sn, dm;
    int e_ring;
    bit e_err;
    int e_act;
    bit e_rdy;
  } vec_t;

  vec_t vq[$];

  task automatic add(bit r, bit tk, int cs, bit sf,
                     bit v, int ix, bit en, int tm,
                     bit sn, bit dm, int er, bit ee,
                     int ea, bit ey);
    vec_t x;
    x = '{r, tk, cs, sf, v, ix, en, tm, sn, dm,
          er, ee, ea, ey};
    vq.push_back(x);
  endtask

  task automatic apply(input vec_t x);
    reset = x.r;
    tick = x.tk;
    counter_state = 17'(x.cs);
    set_flag = x.sf;
    cfg_valid = x.v;
    cfg_index = 4'(x.ix);
    cfg_enable = x.en;
    cfg_time = 17'(x.tm);
    snooze = x.sn;
    dismiss = x.dm;
  endtask

  localparam int POOL[8] =
    '{0, 10, 550, 86000, 140, 86399, 200, 740};

  initial begin
    //  r tk cs     sf v ix en tm     sn dm ring err act rdy
    add(1, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    add(0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1);
    add(0, 0, 0,     0, 1, 2, 1, 100,   0, 0, 0, 0, 0, 1);
    add(0, 1, 99,    0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1);
    add(0, 1, 100,   0, 0, 0, 0, 0,     0, 0, 4, 0, 2, 1);
    add(0, 0, 100,   0, 0, 0, 0, 0,     0, 0, 4, 0, 2, 1);
    add(0, 0, 100,   0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 1);
    add(0, 0, 0,     0, 1, 0, 1, 86000, 0, 0, 0, 0, 0, 1);
    add(0, 1, 86000, 0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 1);
    add(0, 0, 86000, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0, 1);
    add(0, 1, 139,   0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1);
    add(0, 1, 140,   0, 0, 0, 0, 0,     0, 0, 1, 0, 0, 1);
    add(0, 0, 140,   0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 1);
    add(0, 0, 0,     0, 1, 5, 1, 0,     0, 0, 0, 1, 0, 1);
    add(0, 0, 0,     0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1);
    add(0, 0, 0,     0, 1, 1, 1, 86400, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0,     0, 1, 1, 1, 300,   0, 0, 0, 0, 0, 1);
    add(0, 0, 0,     0, 1, 3, 1, 500,   0, 0, 0, 0, 0, 1);
    add(0, 1, 300,   0, 0, 0, 0, 0,     0, 0, 2, 0, 1, 1);
    add(0, 1, 500,   0, 0, 0, 0, 0,     1, 0, 8, 0, 3, 1);
    add(0, 0, 500,   0, 0, 0, 0, 0,     0, 1, 0, 0, 0, 1);
    add(0, 1, 500,   0, 0, 0, 0, 0,     0, 0, 8, 0, 3, 1);
    add(0, 1, 501,   0, 0, 0, 0, 0,     0, 0, 8, 0, 3, 1);
    add(0, 1, 502,   0, 0, 0, 0, 0,     0, 0, 8, 0, 3, 1);
    add(0, 1, 503,   0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1);
    add(0, 1, 500,   1, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1);
    add(0, 1, 100,   0, 0, 0, 0, 0,     0, 0, 4, 0, 2, 1);
    add(0, 1, 300,   0, 0, 0, 0, 0,     0, 0, 6, 0, 1, 1);
    add(1, 0, 300,   0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0);
    add(0, 0, 300,   0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1);
    add(0, 1, 300,   0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1);
    add(0, 0, 0,     0, 1, 2, 1, 100,   0, 0, 0, 0, 0, 1);
    add(0, 1, 100,   0, 0, 0, 0, 0,     0, 0, 4, 0, 2, 1);
    add(0, 0, 100,   0, 1, 2, 0, 99999, 0, 0, 0, 0, 0, 1);
    add(0, 1, 100,   0, 0, 0, 0, 0,     0, 0, 0, 0, 0, 1);

    for (int k = 0; k < vq.size(); k++) begin
      apply(vq[k]);
      cycle();
      chk($sformatf("v%0d_ring", k),
          32'(ringing), 32'(vq[k].e_ring));
      chk($sformatf("v%0d_alarm", k),
          32'(alarm_state), 32'(vq[k].e_ring != 0));
      chk($sformatf("v%0d_err", k),
          32'(cfg_error), 32'(vq[k].e_err));
      chk($sformatf("v%0d_act", k),
          32'(active_index), 32'(vq[k].e_act));
      chk($sformatf("v%0d_rdy", k),
          32'(cfg_ready), 32'(vq[k].e_rdy));
      chk_model();
    end

    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 99) == 0;
      tick = $urandom_range(0, 1) == 1;
      counter_state = 17'(POOL[$urandom_range(0, 7)]);
      set_flag = $urandom_range(0, 9) == 0;
      cfg_valid = $urandom_range(0, 9) == 0;
      cfg_index = 4'($urandom_range(0, 5));
      cfg_enable = $urandom_range(0, 3) != 0;
      cfg_time = $urandom_range(0, 7) == 0
               ? 17'(86400 + $urandom_range(0, 3))
               : 17'(POOL[$urandom_range(0, 7)]);
      snooze = $urandom_range(0, 19) == 0;
      dismiss = $urandom_range(0, 19) == 0;
      cycle();
      chk_model();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
